// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: Gray-coded phase
// pairs, step direction, synchronizer depth and post-reset prime length.
package quad_pkg;

   typedef enum logic [1:0] {
      AB_00 = 2'b00,
      AB_01 = 2'b01,
      AB_11 = 2'b11,
      AB_10 = 2'b10
   } ab_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   localparam int SYNC_STAGES  = 2;
   localparam int PRIME_CYCLES = 2;

   function automatic ab_t next_up(input ab_t ab);
      case (ab)
         AB_00:   return AB_01;
         AB_01:   return AB_11;
         AB_11:   return AB_10;
         default: return AB_00;
      endcase
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Per-phase input conditioning: SYNC_STAGES-deep synchronizer, plus a
// DEB_CYCLES debounce filter when QUAD_DEBOUNCE_EN is defined.
module quad_sync_filter
   import quad_pkg::*;
`ifdef QUAD_DEBOUNCE_EN
#(
   parameter int DEB_CYCLES = 4
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic din,
`ifdef QUAD_DEBOUNCE_EN
   input  logic prime,
`endif
   output logic dout,
   output logic seed
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   // seed is the level dout will present next cycle, so the decoder can
   // absorb the pin state at reset release without a spurious transition.
   assign seed = sync_q[SYNC_STAGES-2];

`ifdef QUAD_DEBOUNCE_EN
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYCLES - 1);

   logic          filt_q;
   logic [CW-1:0] deb_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         filt_q  <= 1'b0;
         deb_cnt <= DEB_LOAD;
      end else if (prime) begin
         filt_q  <= sync_q[SYNC_STAGES-2];
         deb_cnt <= DEB_LOAD;
      end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
         if (deb_cnt == '0) begin
            filt_q  <= sync_q[SYNC_STAGES-1];
            deb_cnt <= DEB_LOAD;
         end else begin
            deb_cnt <= deb_cnt - CW'(1);
         end
      end else begin
         deb_cnt <= DEB_LOAD;
      end
   end

   assign dout = filt_q;
`else
   assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: decodes Gray-code phase transitions into step/err
// pulses, a direction flag and a wrapping position count.
// Build option QUAD_DEBOUNCE_EN adds a DEB_CYCLES glitch filter per phase.
//
// state    | meaning
// ST_PRIME | absorb the pin level present after reset; no step/err/count change
// ST_RUN   | decode every synchronized transition
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             up_down,
   output logic             step,
   output logic             err
);

   typedef enum logic {ST_PRIME, ST_RUN} state_t;

   localparam int PRIME_W = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
   localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(PRIME_CYCLES - 1);

   if (DEB_CYCLES < 1) begin : g_deb_cycles_check
      $error("quad_decoder: DEB_CYCLES must be at least 1");
   end

   state_t             state;
   logic [PRIME_W-1:0] prime_cnt;
   ab_t                prev_ab;
   ab_t                ab_s;
   dir_t               dir_q;
   logic [1:0]         pins;
   logic [1:0]         ab_bits;
   logic [1:0]         seed_bits;

   assign pins = {a_in, b_in};

`ifdef QUAD_DEBOUNCE_EN
   logic in_prime;
   assign in_prime = (state == ST_PRIME);
`endif

   for (genvar i = 0; i < 2; i++) begin : g_phase
      quad_sync_filter
`ifdef QUAD_DEBOUNCE_EN
         #(.DEB_CYCLES(DEB_CYCLES))
`endif
      u_sync_filter (
         .clk   (clk),
         .reset (reset),
         .din   (pins[i]),
`ifdef QUAD_DEBOUNCE_EN
         .prime (in_prime),
`endif
         .dout  (ab_bits[i]),
         .seed  (seed_bits[i])
      );
   end

   assign ab_s    = ab_t'(ab_bits);
   assign up_down = dir_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_PRIME;
         prime_cnt <= PRIME_LOAD;
         prev_ab   <= AB_00;
         count     <= '0;
         dir_q     <= DIR_UP;
         step      <= 1'b0;
         err       <= 1'b0;
      end else begin
         step <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_PRIME: begin
               prev_ab <= ab_t'(seed_bits);
               if (prime_cnt == '0) begin
                  state <= ST_RUN;
               end else begin
                  prime_cnt <= prime_cnt - PRIME_W'(1);
               end
            end
            default: begin
               prev_ab <= ab_s;
               if (ab_s == next_up(prev_ab)) begin
                  count <= count + WIDTH'(1);
                  dir_q <= DIR_UP;
                  step  <= 1'b1;
               end else if (prev_ab == next_up(ab_s)) begin
                  count <= count - WIDTH'(1);
                  dir_q <= DIR_DOWN;
                  step  <= 1'b1;
               end else if (ab_bits == ~prev_ab) begin
                  err <= 1'b1;
               end
            end
         endcase
         // Clear wins over a same-cycle step; the pulse and direction still report it.
         if (clr) begin
            count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed Gray sequences, illegal jumps,
// clear, mid-run reset and randomized moves against a position-index model.
module tb_quad_decoder;

   localparam int WIDTH      = 4;
   localparam int DEB_CYCLES = 4;
`ifdef QUAD_DEBOUNCE_EN
   localparam int LAT = 3 + DEB_CYCLES;
`else
   localparam int LAT = 3;
`endif
   localparam int HOLD = LAT + 1;
   localparam int MOD  = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             reset;
   logic             a_in;
   logic             b_in;
   logic             clr;
   logic [WIDTH-1:0] count;
   logic             up_down;
   logic             step;
   logic             err;

   int checks = 0;
   int errors = 0;
   int m_cnt;
   int m_dir;
   logic [1:0] m_ab;
   int step_total;

   always #5 clk = ~clk;

   quad_decoder #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_in    (a_in),
      .b_in    (b_in),
      .clr     (clr),
      .count   (count),
      .up_down (up_down),
      .step    (step),
      .err     (err)
   );

   // Index of a phase pair along the up sequence 00,01,11,10.
   function automatic int gray_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic do_reset(input logic [1:0] ab, input int cycles, input string name);
      int pulses;
      reset = 1'b0;
      clr   = 1'b0;
      {a_in, b_in} = ab;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({count, up_down, step, err} !== {WIDTH'(0), 3'b100}) begin
            errors++;
            $display("FAIL %s_in_reset: got count=%0d up_down=%b step=%b err=%b, expected count=0 up_down=1 step=0 err=0",
                     name, count, up_down, step, err);
         end
      end
      reset  = 1'b1;
      pulses = 0;
      for (int i = 0; i < LAT + 4; i++) begin
         @(negedge clk);
         pulses += int'(step) + int'(err);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pulses != 0 || count !== WIDTH'(0) || up_down !== 1'b1) begin
         errors++;
         $display("FAIL %s_after_release: got pulses=%0d count=%0d up_down=%b, expected pulses=0 count=0 up_down=1",
                  name, pulses, count, up_down);
      end
      m_cnt = 0;
      m_dir = 1;
      m_ab  = ab;
   endtask

   task automatic move(input logic [1:0] ab, input int hold, input string name);
      int d, exp_step, exp_err, steps, errs, both, first;
      d        = (gray_pos(ab) - gray_pos(m_ab) + 4) % 4;
      exp_step = (d == 1 || d == 3) ? 1 : 0;
      exp_err  = (d == 2) ? 1 : 0;
      if (d == 1) begin
         m_cnt = (m_cnt + 1) % MOD;
         m_dir = 1;
      end else if (d == 3) begin
         m_cnt = (m_cnt + MOD - 1) % MOD;
         m_dir = 0;
      end
      m_ab = ab;
      {a_in, b_in} = ab;
      steps = 0; errs = 0; both = 0; first = -1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if ((step || err) && first < 0) first = i;
         steps += int'(step);
         errs  += int'(err);
         if (step && err) both++;
      end
      checks++;
      if (steps != exp_step || errs != exp_err || both != 0) begin
         errors++;
         $display("FAIL %s_pulses: got step=%0d err=%0d both=%0d, expected step=%0d err=%0d both=0",
                  name, steps, errs, both, exp_step, exp_err);
      end
      if (exp_step + exp_err > 0) begin
         checks++;
         if (first != LAT) begin
            errors++;
            $display("FAIL %s_latency: pulse at cycle %0d, expected cycle %0d", name, first, LAT);
         end
      end
      checks++;
      if (count !== WIDTH'(m_cnt) || up_down !== 1'(m_dir)) begin
         errors++;
         $display("FAIL %s_state: got count=%0d up_down=%b, expected count=%0d up_down=%0d",
                  name, count, up_down, m_cnt, m_dir);
      end
      step_total += steps;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset(2'b11, 2, "reset");
   endtask

   task automatic test_up();
      logic [1:0] up_seq [4];
      up_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      do_reset(2'b00, 2, "up_reset");
      step_total = 0;
      for (int i = 0; i < 20; i++) begin
         move(up_seq[i % 4], HOLD, "up");
         if (i == 15) begin
            checks++;
            if (count !== WIDTH'(0)) begin
               errors++;
               $display("FAIL up_wrap: got count=%0d, expected 0", count);
            end
         end
      end
      checks++;
      if (step_total != 20 || count !== WIDTH'(4) || up_down !== 1'b1) begin
         errors++;
         $display("FAIL up_total: got steps=%0d count=%0d up_down=%b, expected steps=20 count=4 up_down=1",
                  step_total, count, up_down);
      end
   endtask

   task automatic test_down();
      logic [1:0] down_seq [4];
      down_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
      step_total = 0;
      for (int i = 0; i < 16; i++) begin
         move(down_seq[i % 4], HOLD, "down");
         if (i == 4) begin
            checks++;
            if (count !== WIDTH'(MOD - 1)) begin
               errors++;
               $display("FAIL down_wrap: got count=%0d, expected %0d", count, MOD - 1);
            end
         end
      end
      checks++;
      if (step_total != 16 || count !== WIDTH'(4) || up_down !== 1'b0) begin
         errors++;
         $display("FAIL down_total: got steps=%0d count=%0d up_down=%b, expected steps=16 count=4 up_down=0",
                  step_total, count, up_down);
      end
   endtask

   task automatic test_illegal();
      move(2'b11, HOLD, "illegal_jump");
      move(2'b10, HOLD, "after_illegal");
      checks++;
      if (count !== WIDTH'(5) || up_down !== 1'b1) begin
         errors++;
         $display("FAIL illegal_recover: got count=%0d up_down=%b, expected count=5 up_down=1", count, up_down);
      end
      move(2'b00, HOLD, "to_six");
      move(2'b01, HOLD, "to_seven");
   endtask

   task automatic test_clear();
      checks++;
      if (count !== WIDTH'(7)) begin
         errors++;
         $display("FAIL clear_pre: got count=%0d, expected 7", count);
      end
      {a_in, b_in} = 2'b11;
      for (int i = 0; i < LAT - 1; i++) begin
         @(posedge clk);
         #1;
      end
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if (step !== 1'b1 || err !== 1'b0 || count !== WIDTH'(0) || up_down !== 1'b1) begin
         errors++;
         $display("FAIL clear_with_step: got step=%b err=%b count=%0d up_down=%b, expected step=1 err=0 count=0 up_down=1",
                  step, err, count, up_down);
      end
      m_cnt = 0;
      m_dir = 1;
      m_ab  = 2'b11;
      @(negedge clk);
      checks++;
      if (step !== 1'b0 || count !== WIDTH'(0)) begin
         errors++;
         $display("FAIL clear_hold: got step=%b count=%0d, expected step=0 count=0", step, count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [1:0] ab;
      for (int i = 0; i < 40; i++) begin
         ab = 2'($urandom_range(0, 3));
         move(ab, int'($urandom_range(HOLD, HOLD + 3)), "random");
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] nb;
      if (m_cnt == 0) move(2'b01 ^ {1'b0, 1'b0} ^ (m_ab == 2'b00 ? 2'b00 : 2'b00) ^ 2'b00 | (m_ab == 2'b00 ? 2'b01 : m_ab ^ 2'b01), HOLD, "mid_pre");
      // Start a legal step, then reset while it is still in the synchronizer.
      nb = m_ab ^ 2'b10;
      {a_in, b_in} = nb;
      @(posedge clk);
      #1;
      do_reset(nb, 1, "reset_mid");
      move(nb ^ 2'b01, HOLD, "after_mid_reset");
   endtask

`ifdef QUAD_DEBOUNCE_EN
   task automatic test_debounce();
      logic [1:0] g;
      int pulses;
      int cnt0;
      cnt0 = m_cnt;
      g = m_ab ^ 2'b10;
      {a_in, b_in} = g;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
      end
      {a_in, b_in} = m_ab;
      pulses = 0;
      for (int i = 0; i < LAT + 6; i++) begin
         @(negedge clk);
         pulses += int'(step) + int'(err);
      end
      checks++;
      if (pulses != 0 || count !== WIDTH'(cnt0)) begin
         errors++;
         $display("FAIL deb_glitch: got pulses=%0d count=%0d, expected pulses=0 count=%0d", pulses, count, cnt0);
      end
      @(posedge clk);
      #1;
      move(g, DEB_CYCLES + 4, "deb_level");
   endtask
`endif

   initial begin
      reset = 1'b0;
      clr   = 1'b0;
      a_in  = 1'b1;
      b_in  = 1'b1;
      m_cnt = 0;
      m_dir = 1;
      m_ab  = 2'b00;
      step_total = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_up();
      test_down();
      test_illegal();
      test_clear();
      test_random();
      test_reset_mid();
`ifdef QUAD_DEBOUNCE_EN
      test_debounce();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
